// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between a pipeline and the HI/LO unit
//
// Purpose: groups the request strobe, opcode, operands and the HI/LO results.
// Ports (signals):
//   start        request strobe
//   op[2:0]      operation code
//   rs_data      operand A (dividend / multiplicand)
//   rt_data      operand B (divisor / multiplier)
//   busy         a division is iterating
//   done         one-cycle completion pulse
//   div_by_zero  flags a divide with a zero divisor, only together with done
//   hi, lo       architectural HI/LO registers
// Modports: master drives requests, slave (the unit) drives results.

interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - MIPS-style HI/LO multiply/divide unit
//
// Purpose: single-cycle MULT/MULTU/MTHI/MTLO and an optional 32-cycle
// restoring divider (DIV/DIVU) writing the architectural HI/LO registers.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mult_div_unit_if.slave (start/op/rs_data/rt_data in,
//          busy/done/div_by_zero/hi/lo out)
// Configuration macro: MDU_DIV_EN builds the divider; without it DIV/DIVU
// complete as one-cycle no-ops and busy/div_by_zero are tied low.

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  state_t             state, state_next;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_int;
  logic               accept;
  logic [2*WIDTH-1:0] prod_s, prod_u;

  // Operands widened to the product width so the low 2*WIDTH bits of the
  // multiply are the exact signed / unsigned product.
  assign prod_s = $signed({{WIDTH{bus.rs_data[WIDTH-1]}}, bus.rs_data}) *
                  $signed({{WIDTH{bus.rt_data[WIDTH-1]}}, bus.rt_data});
  assign prod_u = {{WIDTH{1'b0}}, bus.rs_data} * {{WIDTH{1'b0}}, bus.rt_data};

  assign accept = bus.start && !busy_int;

`ifdef MDU_DIV_EN
  logic             is_div, div_zero, signed_op;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_quo, neg_rem, dz_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step;

  assign is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign div_zero  = (bus.rt_data == '0);
  assign signed_op = (bus.op == OP_DIV);
  assign mag_a     = (signed_op && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
  assign mag_b     = (signed_op && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and keep the subtraction only when it does not go negative. The quotient
  // register doubles as the dividend shift register.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  assign busy_int        = (state == DIV_RUN);
  assign bus.div_by_zero = dz_q;
`else
  assign busy_int        = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.busy = busy_int;
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (accept) state_next = DONE;
`ifdef MDU_DIV_EN
    if (accept && is_div && !div_zero) state_next = DIV_RUN;
    if (state == DIV_RUN) state_next = (cnt == 6'd31) ? DONE : DIV_RUN;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
`ifdef MDU_DIV_EN
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
`ifdef MDU_DIV_EN
      dz_q <= 1'b0;
`endif
      if (accept) begin
        case (bus.op)
          OP_MULT:  {hi_q, lo_q} <= prod_s;
          OP_MULTU: {hi_q, lo_q} <= prod_u;
          OP_MTHI:  hi_q <= bus.rs_data;
          OP_MTLO:  lo_q <= bus.rs_data;
`ifdef MDU_DIV_EN
          OP_DIV, OP_DIVU: begin
            if (div_zero) begin
              dz_q <= 1'b1;
            end else begin
              cnt     <= '0;
              rem_q   <= '0;
              quo_q   <= mag_a;
              dvs_q   <= mag_b;
              neg_quo <= signed_op && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
              neg_rem <= signed_op && bus.rs_data[WIDTH-1];
            end
          end
`endif
          default: ;
        endcase
      end
`ifdef MDU_DIV_EN
      else if (state == DIV_RUN) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        if (cnt == 6'd31) begin
          cnt  <= '0;
          lo_q <= neg_quo ? -quo_step : quo_step;
          hi_q <= neg_rem ? -rem_step : rem_step;
        end else begin
          cnt <= cnt + 6'd1;
        end
      end
`endif
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request strobe, sampled on rising clk.
REQ-005 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 SHALL have port rs_data  input  32  operand A (dividend/multiplicand), driven from register-file r_data1.
REQ-007 SHALL have port rt_data  input  32  operand B (divisor/multiplier), driven from register-file r_data2.
REQ-008 SHALL have port busy  output  1  high while a division iterates.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port div_by_zero  output  1  pulses with done when a divide had rt_data=0.
REQ-011 SHALL have ports hi and lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL accept a request on edge N when start=1 and busy=0; start while busy=1 SHALL be ignored with no state change.
REQ-013 SHALL capture rs_data/rt_data at the accept edge; operand changes afterwards SHALL have no effect.
REQ-014 SHALL implement states IDLE, DIV_RUN, DONE: IDLE/DONE->DIV_RUN on accepted DIV/DIVU with rt_data!=0; DIV_RUN->DONE after 32 iterations; DONE->IDLE after one cycle unless a new request is accepted.
REQ-015 MULT/MULTU SHALL write the 64-bit product {hi,lo} at edge N (signed / unsigned respectively), done=1 for the cycle after edge N, busy stays 0.
REQ-016 MTHI/MTLO SHALL write rs_data to hi/lo at edge N, other register unchanged, done=1 for the cycle after edge N.
REQ-017 DIV/DIVU SHALL use restoring division, one quotient bit per cycle, using a 6-bit iteration counter counting 0..31.
REQ-018 For division, busy SHALL be 1 for exactly 32 cycles (after edges N..N+31), lo=quotient and hi=remainder SHALL be written at edge N+32, done=1 for the cycle after edge N+32.
REQ-019 DIV SHALL divide magnitudes; quotient negated when operand signs differ; remainder carries the dividend's sign.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, no flag.
REQ-021 DIV/DIVU with rt_data=0 SHALL leave hi/lo unchanged, with done=1 and div_by_zero=1 for the cycle after edge N and no DIV_RUN.
REQ-022 Reserved op codes SHALL be no-ops: hi/lo unchanged, done=1 for the cycle after edge N.
REQ-023 A request accepted in the DONE cycle SHALL be legal; the new done SHALL follow its own latency.
REQ-024 div_by_zero SHALL be 0 whenever done=0.

Reset
REQ-025 With reset=1 at a rising edge, the block SHALL set hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, and iteration counter=0.
REQ-026 Reset SHALL take priority over start; reset during DIV_RUN SHALL abort the division with no done pulse.

Configuration
REQ-027 With macro MDU_DIV_EN defined, the divider SHALL be built per REQ-017..REQ-021.
REQ-028 Without MDU_DIV_EN, there SHALL be no divider logic and no DIV_RUN state; DIV/DIVU SHALL behave as REQ-022 no-ops; busy and div_by_zero SHALL be tied to 0.

Verification
REQ-029 The bench SHALL cover MULT with rs=0xFFFFFFFE and rt=0x00000003: {hi,lo} SHALL be 0xFFFFFFFF_FFFFFFFA, with done one cycle after accept.
REQ-030 The bench SHALL cover MULTU with the same operands: hi SHALL be 0x00000002 and lo 0xFFFFFFFA.
REQ-031 The bench SHALL cover DIV with rs=-7 and rt=2: busy SHALL be high for 32 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), and done SHALL pulse once.
REQ-032 The bench SHALL cover DIVU with rs=100 and rt=0: done=1 and div_by_zero=1 one cycle after accept, with hi/lo unchanged.
REQ-033 The bench SHALL cover DIVU 100/7 started, a MTHI asserted with start at cycle 5, and reset at cycle 10: MTHI SHALL be ignored, and after reset hi=lo=0 with no done.
REQ-034 The bench SHALL cover a build without MDU_DIV_EN running DIV 9/3: done SHALL occur after 1 cycle, hi/lo SHALL be unchanged, and busy SHALL never assert.
